multicycle_control_sequencer: RTL and testbench

- Multi-cycle controller for the 16-bit datapath (4-bit opcode, 2-bit funct in instr[1:0]).
- Breaks each instruction into FETCH/DECODE/EXEC/MEM/WB phases.
- Drives every datapath control input plus an explicit PC write enable, so PC, register-file and data-memory updates each happen in exactly one cycle.
- Waits on a memory-ready handshake in MEM; exposes run/halt status and a retired-instruction counter.

---
 rtl/multicycle_control_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_multicycle_control_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_sequencer
// Purpose  : FETCH/DECODE/EXEC/MEM/WB controller for the 16-bit datapath;
//            optional MEM wait timeout enabled by defining MEM_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control_sequencer #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W          = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic             mem_ready,
  output logic             RegDst,
  output logic             Branch,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic             MemToReg,
  output logic             ALUSrc,
  output logic             Shift,
  output logic [1:0]       ALUOp,
  output logic             pc_write,
  output logic             busy,
  output logic             halted,
  output logic             illegal_op,
  output logic             mem_err,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [3:0] c_OP_R     = 4'b0000;
  localparam logic [3:0] c_OP_SHIFT = 4'b0001;
  localparam logic [3:0] c_OP_ADDI  = 4'b0010;
  localparam logic [3:0] c_OP_LW    = 4'b0100;
  localparam logic [3:0] c_OP_SW    = 4'b0101;
  localparam logic [3:0] c_OP_BEQ   = 4'b0110;
  localparam logic [3:0] c_OP_HALT  = 4'b1111;

  state_t           r_state;
  state_t           w_next;
  logic [3:0]       r_opcode;
  logic             r_illegal;
  logic [CNT_W-1:0] r_count;
  logic             w_set_illegal;
  logic             w_timeout;
  logic             w_is_lw;
  logic             w_is_sw;
  logic             w_is_legal;

  assign w_is_lw    = (r_opcode == c_OP_LW);
  assign w_is_sw    = (r_opcode == c_OP_SW);
  assign w_is_legal = (r_opcode == c_OP_R)  || (r_opcode == c_OP_SHIFT) ||
                      (r_opcode == c_OP_ADDI) || w_is_lw || w_is_sw ||
                      (r_opcode == c_OP_BEQ);

`ifdef MEM_TIMEOUT_EN
  localparam int c_WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [c_WAIT_W-1:0] r_wait;
  logic                r_mem_err;

  // Fires in the last allowed MEM cycle; a same-cycle mem_ready still completes.
  assign w_timeout = (r_state == S_MEM) && !mem_ready &&
                     (r_wait == c_WAIT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_wait    <= '0;
      r_mem_err <= 1'b0;
    end else begin
      if (r_state != S_MEM) begin
        r_wait <= '0;
      end else if (!mem_ready) begin
        r_wait <= r_wait + c_WAIT_W'(1);
      end
      if (w_timeout) begin
        r_mem_err <= 1'b1;
      end
    end
  end

  assign mem_err = r_mem_err;
`else
  assign w_timeout = 1'b0;
  assign mem_err   = 1'b0;
`endif

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state   <= S_IDLE;
      r_opcode  <= 4'b0000;
      r_illegal <= 1'b0;
      r_count   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_FETCH) begin
        r_opcode <= opcode;
      end
      if (w_set_illegal) begin
        r_illegal <= 1'b1;
      end
      if (pc_write) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_next        = r_state;
    RegDst        = 1'b0;
    Branch        = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    RegWrite      = 1'b0;
    MemToReg      = 1'b0;
    ALUSrc        = 1'b0;
    Shift         = 1'b0;
    ALUOp         = 2'b00;
    pc_write      = 1'b0;
    w_set_illegal = 1'b0;

    // Mux selects follow the latched opcode for the whole decoded instruction.
    if ((r_state == S_DECODE) || (r_state == S_EXEC) ||
        (r_state == S_MEM) || (r_state == S_WB)) begin
      case (r_opcode)
        c_OP_R:     begin RegDst = 1'b1; ALUOp = 2'b10; end
        c_OP_SHIFT: begin RegDst = 1'b1; Shift = 1'b1; end
        c_OP_ADDI:  ALUSrc = 1'b1;
        c_OP_LW:    begin ALUSrc = 1'b1; MemToReg = 1'b1; end
        c_OP_SW:    ALUSrc = 1'b1;
        c_OP_BEQ:   ALUOp = 2'b01;
        default:    ;
      endcase
    end

    case (r_state)
      S_IDLE:   if (start) w_next = S_FETCH;
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        if (r_opcode == c_OP_HALT) begin
          w_next = S_HALT;
        end else if (!w_is_legal) begin
          pc_write      = 1'b1;
          w_set_illegal = 1'b1;
          w_next        = S_FETCH;
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        if (r_opcode == c_OP_BEQ) begin
          Branch   = 1'b1;
          pc_write = 1'b1;
          w_next   = S_FETCH;
        end else if (w_is_lw || w_is_sw) begin
          w_next = S_MEM;
        end else begin
          w_next = S_WB;
        end
      end
      S_MEM: begin
        MemRead  = w_is_lw;
        MemWrite = w_is_sw;
        if (mem_ready) begin
          if (w_is_sw) begin
            pc_write = 1'b1;
            w_next   = S_FETCH;
          end else begin
            w_next = S_WB;
          end
        end else if (w_timeout) begin
          w_next = S_HALT;
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        pc_write = 1'b1;
        w_next   = S_FETCH;
      end
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_IDLE;
    endcase
  end

  assign busy        = (r_state != S_IDLE) && (r_state != S_HALT);
  assign halted      = (r_state == S_HALT);
  assign illegal_op  = r_illegal;
  assign instr_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_sequencer.sv
`default_nettype none
// Testbench for multicycle_control_sequencer: per-instruction cycle-schedule
// model checked every cycle, plus directed scenarios with literal expectations.
module tb_multicycle_control_sequencer;

  localparam int TB_CNT_W   = 6;
  localparam int TB_TIMEOUT = 15;

  localparam int K_ALU  = 0;
  localparam int K_LW   = 1;
  localparam int K_SW   = 2;
  localparam int K_BEQ  = 3;
  localparam int K_HALT = 4;
  localparam int K_ILL  = 5;

  logic                Clock = 1'b0;
  logic                Reset = 1'b1;
  logic                start = 1'b0;
  logic [3:0]          opcode = 4'h0;
  logic                mem_ready = 1'b0;
  logic                RegDst, Branch, MemRead, MemWrite, RegWrite, MemToReg;
  logic                ALUSrc, Shift, pc_write, busy, halted, illegal_op, mem_err;
  logic [1:0]          ALUOp;
  logic [TB_CNT_W-1:0] instr_count;

  multicycle_control_sequencer #(
    .TIMEOUT_CYCLES(TB_TIMEOUT),
    .CNT_W         (TB_CNT_W)
  ) dut (
    .Clock(Clock), .Reset(Reset), .start(start), .opcode(opcode),
    .mem_ready(mem_ready), .RegDst(RegDst), .Branch(Branch),
    .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .MemToReg(MemToReg), .ALUSrc(ALUSrc), .Shift(Shift), .ALUOp(ALUOp),
    .pc_write(pc_write), .busy(busy), .halted(halted),
    .illegal_op(illegal_op), .mem_err(mem_err), .instr_count(instr_count)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic       reg_dst, branch, mem_read, mem_write, reg_write, mem_to_reg, alu_src, shift;
    logic [1:0] alu_op;
    logic       pc_write, busy, halted, illegal, mem_err;
  } ctrl_t;

  ctrl_t               exp_c = '0;
  ctrl_t               act_c;
  logic [TB_CNT_W-1:0] exp_cnt = '0;
  bit                  chk_en = 1'b0;
  int                  total = 0;
  int                  bad = 0;

  // model state
  int m_cnt = 0;
  bit m_illegal = 1'b0;
  bit m_mem_err = 1'b0;

  // observed per-instruction statistics
  int st_pcw_n, st_pcw_cycle, st_strobe_n, st_branch_n, st_regwrite_n;

  assign act_c = {RegDst, Branch, MemRead, MemWrite, RegWrite, MemToReg, ALUSrc, Shift,
                  ALUOp, pc_write, busy, halted, illegal_op, mem_err};

  always @(negedge Clock) begin
    if (chk_en) begin
      #2;
      total++;
      if (act_c !== exp_c) begin
        bad++;
        $display("FAIL ctrl t=%0t got=%h expected=%h", $time, act_c, exp_c);
      end
      total++;
      if (instr_count !== exp_cnt) begin
        bad++;
        $display("FAIL instr_count t=%0t got=%0d expected=%0d", $time, instr_count, exp_cnt);
      end
    end
  end

  task automatic check_lit(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", name, act, expv);
    end
  endtask

  function automatic int kind_of(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b0010: return K_ALU;
      4'b0100: return K_LW;
      4'b0101: return K_SW;
      4'b0110: return K_BEQ;
      4'b1111: return K_HALT;
      default: return K_ILL;
    endcase
  endfunction

  function automatic ctrl_t mux_of(input logic [3:0] op);
    ctrl_t c = '0;
    case (op)
      4'b0000: begin c.reg_dst = 1'b1; c.alu_op = 2'b10; end
      4'b0001: begin c.reg_dst = 1'b1; c.shift = 1'b1; end
      4'b0010: c.alu_src = 1'b1;
      4'b0100: begin c.alu_src = 1'b1; c.mem_to_reg = 1'b1; end
      4'b0101: c.alu_src = 1'b1;
      4'b0110: c.alu_op = 2'b01;
      default: ;
    endcase
    return c;
  endfunction

  function automatic ctrl_t sticky_base();
    ctrl_t c = '0;
    c.illegal = m_illegal;
    c.mem_err = m_mem_err;
    return c;
  endfunction

  // Reset, then one idle cycle with start low and one with start high.
  task automatic do_reset();
    @(negedge Clock);
    Reset = 1'b1; start = 1'b0;
    m_cnt = 0; m_illegal = 1'b0; m_mem_err = 1'b0;
    exp_c = '0; exp_cnt = '0;
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    start = 1'b1;
  endtask

  // Runs one instruction from its FETCH cycle; abort_at>0 asserts Reset in that cycle.
  task automatic run_instr(input logic [3:0] op, input int waits, input int abort_at);
    int    kd, len, mem_cycles;
    bit    tmo, in_mem;
    ctrl_t c;
    kd  = kind_of(op);
    tmo = 1'b0;
`ifdef MEM_TIMEOUT_EN
    if ((kd == K_LW || kd == K_SW) && waits >= TB_TIMEOUT) tmo = 1'b1;
`endif
    case (kd)
      K_ALU:   len = 4;
      K_LW:    len = 5 + waits;
      K_SW:    len = 4 + waits;
      K_BEQ:   len = 3;
      default: len = 2;
    endcase
    mem_cycles = tmo ? TB_TIMEOUT : waits + 1;
    if (tmo) len = 3 + TB_TIMEOUT;
    st_pcw_n = 0; st_pcw_cycle = 0; st_strobe_n = 0; st_branch_n = 0; st_regwrite_n = 0;
    for (int k = 1; k <= len; k++) begin
      @(negedge Clock);
      if (k == abort_at) begin
        Reset = 1'b1;
        m_cnt = 0; m_illegal = 1'b0; m_mem_err = 1'b0;
        exp_c = '0; exp_cnt = '0;
        #1;
        check_lit("reset_drops_memwrite", int'(MemWrite), 0);
        return;
      end
      opcode    = (k == 1) ? op : 4'($urandom);
      start     = 1'($urandom);
      in_mem    = (kd == K_LW || kd == K_SW) && k >= 4 && k < 4 + mem_cycles;
      mem_ready = in_mem ? (!tmo && k == 3 + mem_cycles) : 1'($urandom);
      c = (k >= 2) ? mux_of(op) : '0;
      c.busy      = 1'b1;
      c.illegal   = m_illegal;
      c.mem_err   = m_mem_err;
      c.mem_read  = (kd == K_LW) && in_mem;
      c.mem_write = (kd == K_SW) && in_mem;
      c.branch    = (kd == K_BEQ) && k == 3;
      c.reg_write = (kd == K_ALU || kd == K_LW) && k == len;
      c.pc_write  = (kd != K_HALT) && !tmo && k == len;
      exp_c   = c;
      exp_cnt = TB_CNT_W'(m_cnt);
      #1;
      if (pc_write) begin st_pcw_n++; st_pcw_cycle = k; end
      if (MemRead || MemWrite) st_strobe_n++;
      if (Branch) st_branch_n++;
      if (RegWrite) st_regwrite_n++;
    end
    if (kd != K_HALT && !tmo) m_cnt = (m_cnt + 1) % (1 << TB_CNT_W);
    if (kd == K_ILL) m_illegal = 1'b1;
    if (tmo) m_mem_err = 1'b1;
  endtask

  task automatic halt_cycles(input int n);
    ctrl_t c;
    for (int k = 0; k < n; k++) begin
      @(negedge Clock);
      start     = 1'($urandom);
      mem_ready = 1'($urandom);
      opcode    = 4'($urandom);
      c = sticky_base();
      c.halted = 1'b1;
      exp_c   = c;
      exp_cnt = TB_CNT_W'(m_cnt);
    end
  endtask

  initial begin
    logic [3:0] op;
    logic [3:0] legal_ops [6];
    logic [3:0] ill_ops [10];
    legal_ops = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6};
    ill_ops   = '{4'h3, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'h3};
    chk_en = 1'b1;

    // R-type
    do_reset();
    run_instr(4'b0000, 0, 0);
    check_lit("r_pcw_cycle", st_pcw_cycle, 4);
    check_lit("r_pcw_count", st_pcw_n, 1);
    check_lit("r_regwrite_count", st_regwrite_n, 1);
    @(posedge Clock); #1;
    check_lit("r_instr_count", int'(instr_count), 1);

    // LW with three wait cycles
    do_reset();
    run_instr(4'b0100, 3, 0);
    check_lit("lw_memread_cycles", st_strobe_n, 4);
    check_lit("lw_pcw_cycle", st_pcw_cycle, 8);
    @(posedge Clock); #1;
    check_lit("lw_instr_count", int'(instr_count), 1);

    // BEQ
    do_reset();
    run_instr(4'b0110, 0, 0);
    check_lit("beq_branch_count", st_branch_n, 1);
    check_lit("beq_pcw_cycle", st_pcw_cycle, 3);
    check_lit("beq_regwrite_count", st_regwrite_n, 0);

    // Illegal followed by a normal instruction
    do_reset();
    run_instr(4'b1010, 0, 0);
    check_lit("ill_pcw_cycle", st_pcw_cycle, 2);
    check_lit("ill_strobes", st_strobe_n + st_regwrite_n + st_branch_n, 0);
    run_instr(4'b0010, 0, 0);
    check_lit("ill_sticky", int'(illegal_op), 1);
    check_lit("after_ill_pcw_cycle", st_pcw_cycle, 4);

    // HALT: absorbing, start ignored
    do_reset();
    run_instr(4'b1111, 0, 0);
    check_lit("halt_pcw_count", st_pcw_n, 0);
    halt_cycles(6);
    #1;
    check_lit("halt_halted", int'(halted), 1);
    check_lit("halt_busy", int'(busy), 0);

    // Reset in the middle of an SW memory wait
    do_reset();
    run_instr(4'b0101, 4, 6);
    #1;
    check_lit("abort_busy", int'(busy), 0);

    // Randomized instruction stream
    do_reset();
    for (int i = 0; i < 160; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        run_instr(4'b1111, 0, 0);
        halt_cycles(2);
        do_reset();
      end else begin
        if ($urandom_range(0, 7) == 0) op = ill_ops[$urandom_range(0, 9)];
        else op = legal_ops[$urandom_range(0, 5)];
        run_instr(op, $urandom_range(0, 5), 0);
      end
    end

`ifdef MEM_TIMEOUT_EN
    do_reset();
    run_instr(4'b0101, TB_TIMEOUT, 0);
    check_lit("tmo_pcw_count", st_pcw_n, 0);
    check_lit("tmo_strobe_cycles", st_strobe_n, TB_TIMEOUT);
    halt_cycles(3);
    #1;
    check_lit("tmo_mem_err", int'(mem_err), 1);
    check_lit("tmo_halted", int'(halted), 1);
`endif

    @(posedge Clock);
    chk_en = 1'b0;
    #10;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
